// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL AB / DIV AB unit for the 8051 core.
// Shift-add multiply and restoring divide, one bit per clock.
module mul_div_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic              wr_ab,
  output logic [DATA_W-1:0] res_a,
  output logic [DATA_W-1:0] res_b,
  output logic              ov,
  output logic              cy
);

  localparam int W  = DATA_W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q;
  logic           op_q;
  logic [W-1:0]   opnd_q;
  logic [2*W:0]   acc_q;
  logic [2*W:0]   acc_d;
  logic [CW-1:0]  cnt_q;

  logic [W:0]     hi_sum;
  logic [W:0]     rem_sh;
  logic           ge;
  logic [W-1:0]   diff;

  // MUL: {hi, multiplier}; DIV: {rem, quo} with quo preloaded by dividend
  always_comb begin
    acc_d  = acc_q;
    hi_sum = '0;
    rem_sh = '0;
    ge     = 1'b0;
    diff   = '0;
    if (!op_q) begin
      hi_sum = acc_q[2*W:W] + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_d  = {hi_sum, acc_q[W-1:0]} >> 1;
    end else begin
      rem_sh = acc_q[2*W-1:W-1];
      ge     = rem_sh >= {1'b0, opnd_q};
      diff   = rem_sh[W-1:0] - opnd_q;
      if (ge)
        acc_d = {1'b0, diff, acc_q[W-2:0], 1'b1};
      else
        acc_d = {1'b0, rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  assign wr_ab = done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      res_a   <= '0;
      res_b   <= '0;
      ov      <= 1'b0;
      cy      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            cnt_q <= '0;
            if (op) begin
              opnd_q <= src_b;
              acc_q  <= {{(W+1){1'b0}}, src_a};
            end else begin
              opnd_q <= src_a;
              acc_q  <= {{(W+1){1'b0}}, src_b};
            end
            if (op && src_b == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= CALC;
              busy    <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            state_q <= DONE;
            busy    <= 1'b0;
          end
        end
        DONE: begin
          done    <= 1'b1;
          state_q <= IDLE;
          res_a   <= acc_q[W-1:0];
          res_b   <= acc_q[2*W-1:W];
          ov      <= op_q ? (opnd_q == '0) : (|acc_q[2*W-1:W]);
          cy      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit (8-bit and 4-bit).
// Expected results are queued at issue and popped on done.
module tb_mul_div_unit;

  logic       clock;
  logic       reset;
  logic       start, op;
  logic [7:0] src_a, src_b;
  logic       busy, done, wr_ab, ov, cy;
  logic [7:0] res_a, res_b;

  logic       start4, op4;
  logic [3:0] src_a4, src_b4;
  logic       busy4, done4, wr_ab4, ov4, cy4;
  logic [3:0] res_a4, res_b4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int a;
    int b;
    int ov;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];

  mul_div_unit #(.DATA_W(8)) u8 (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .wr_ab(wr_ab), .res_a(res_a), .res_b(res_b), .ov(ov), .cy(cy)
  );

  mul_div_unit #(.DATA_W(4)) u4 (
    .clock(clock), .reset(reset), .start(start4), .op(op4),
    .src_a(src_a4), .src_b(src_b4), .busy(busy4), .done(done4),
    .wr_ab(wr_ab4), .res_a(res_a4), .res_b(res_b4), .ov(ov4), .cy(cy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(int w, bit o, int a, int b);
    exp_t e;
    int   mask, p;
    mask = (1 << w) - 1;
    if (!o) begin
      p     = a * b;
      e.a   = p & mask;
      e.b   = (p >> w) & mask;
      e.ov  = (p > mask) ? 1 : 0;
      e.lat = w + 2;
    end else if (b == 0) begin
      e.a   = a;
      e.b   = 0;
      e.ov  = 1;
      e.lat = 2;
    end else begin
      e.a   = a / b;
      e.b   = a % b;
      e.ov  = 0;
      e.lat = w + 2;
    end
    return e;
  endfunction

  task automatic check(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(bit o, int a, int b, bit push);
    op    = o;
    src_a = a[7:0];
    src_b = b[7:0];
    start = 1'b1;
    if (push) sb.push_back(model(8, o, a, b));
  endtask

  task automatic wait_done(string tag, bit disturb);
    int   k, busy_n;
    bit   seen;
    exp_t e;
    k = 0; busy_n = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        start = 1'b0;
        if (disturb) begin
          src_a = 8'hA5;
          src_b = 8'h3C;
        end
      end
      if (disturb && k == 3) begin
        start = 1'b1;
        op    = ~op;
      end
      if (disturb && k == 4) start = 1'b0;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check({tag, "_lat"},  k, e.lat);
    check({tag, "_busy"}, busy_n, e.lat - 2);
    check({tag, "_a"},    int'(res_a), e.a);
    check({tag, "_b"},    int'(res_b), e.b);
    check({tag, "_ov"},   int'(ov), e.ov);
    check({tag, "_cy"},   int'(cy), 0);
    check({tag, "_wr"},   int'(wr_ab), 1);
  endtask

  task automatic run4(string tag, bit o, int a, int b);
    int   k;
    bit   seen;
    exp_t e;
    op4    = o;
    src_a4 = a[3:0];
    src_b4 = b[3:0];
    start4 = 1'b1;
    sb4.push_back(model(4, o, a, b));
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      if (k == 1) start4 = 1'b0;
      if (done4) seen = 1;
    end
    e = sb4.pop_front();
    check({tag, "_lat"}, k, e.lat);
    check({tag, "_a"},   int'(res_a4), e.a);
    check({tag, "_b"},   int'(res_b4), e.b);
    check({tag, "_ov"},  int'(ov4), e.ov);
    @(negedge clock);
  endtask

  initial begin
    int dn;
    reset  = 1'b0;
    start  = 1'b0; op  = 1'b0; src_a  = '0; src_b  = '0;
    start4 = 1'b0; op4 = 1'b0; src_a4 = '0; src_b4 = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr",   int'(wr_ab), 0);
    check("rst_a",    int'(res_a), 0);
    check("rst_b",    int'(res_b), 0);
    check("rst_ov",   int'(ov), 0);
    check("rst_cy",   int'(cy), 0);
    reset = 1'b1;
    @(negedge clock);

    issue(0, 8'h0C, 8'h0A, 1);
    wait_done("mul_0c_0a", 0);
    @(negedge clock);
    check("done_drop", int'(done), 0);
    check("wr_drop",   int'(wr_ab), 0);
    check("hold_a",    int'(res_a), 8'h78);

    issue(0, 8'h50, 8'hA0, 1);
    wait_done("mul_50_a0", 0);
    @(negedge clock);
    issue(0, 8'hFF, 8'hFF, 1);
    wait_done("mul_ff_ff", 0);
    @(negedge clock);
    issue(1, 8'hFB, 8'h12, 1);
    wait_done("div_fb_12", 0);
    @(negedge clock);
    issue(1, 8'h07, 8'h09, 1);
    wait_done("div_07_09", 0);
    @(negedge clock);
    issue(1, 8'h55, 8'h00, 1);
    wait_done("div_55_00", 0);
    @(negedge clock);

    issue(0, 8'h0C, 8'h0A, 1);
    wait_done("mul_disturb", 1);
    issue(1, 8'hFB, 8'h12, 1);
    wait_done("div_b2b", 0);
    @(negedge clock);

    issue(0, 8'h0C, 8'h0A, 0);
    repeat (4) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_a",    int'(res_a), 0);
    check("abort_b",    int'(res_b), 0);
    check("abort_ov",   int'(ov), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) dn++;
    end
    check("abort_nodone", dn, 0);
    issue(0, 8'h02, 8'h03, 1);
    wait_done("mul_02_03", 0);
    @(negedge clock);

    run4("w4_mul_f_f", 0, 4'hF, 4'hF);
    run4("w4_div_d_3", 1, 4'hD, 4'h3);
    run4("w4_div_9_0", 1, 4'h9, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
